apb_intc: RTL and testbench
===========================

// Module: apb_intc
// PURPOSE
//  APB peripheral interrupt controller occupying the intc slave slot (psel_s4) of the APB bridge.
//  Collects the 40 level interrupt lines (xx_intc_vld), latches them as pending, arbitrates by
//  programmable priority and presents one irq plus a source ID to the CPU.
//  Claim/complete handshake through APB guarantees one in-service instance per source.
// PARAMETERS
//  NUM_SRC  40  number of interrupt sources; source i maps to bit i of xx_intc_vld
//  PRIO_W   2   priority width; 0 = never interrupts, larger value = higher priority
//  ID_W     6   width of claim ID; ID = source index + 1, ID 0 = no interrupt
// PORTS
//  pclk          in   1        peripheral clock (per_clk)
//  presetn       in   1        asynchronous active-low reset (pad_cpu_rst_b)
//  psel          in   1        APB select
//  penable       in   1        APB enable
//  pwrite        in   1        APB write
//  paddr         in   12       APB byte address (apb_xx_paddr[11:0])
//  pwdata        in   32       APB write data
//  prdata        out  32       APB read data
//  xx_intc_vld   in   NUM_SRC  level interrupt requests, active high
//  intc_cpu_irq  out  1        interrupt request to CPU, registered
//  intc_cpu_id   out  ID_W     ID of current winner, registered; 0 when irq low
// BEHAVIOUR
//  One clock; reset is asynchronous and active-low (pclk, presetn). Reset: all pending/in-service/enable
//  = 0, all PRIO = 0, THRESH = 0, intc_cpu_irq = 0, intc_cpu_id = 0, prdata = 0.
//  APB: zero wait states; access = psel & penable; register side effects once per access.
//  prdata driven combinationally during access of a read, else 0. Undefined offsets read 0, writes ignored.
//  Map: 0x000 PEND_LO RO [31:0]; 0x004 PEND_HI RO [NUM_SRC-33:0]; 0x008 EN_LO RW; 0x00C EN_HI RW;
//   0x010 THRESH RW [PRIO_W-1:0]; 0x014 CLAIM (read=claim, write=complete); 0x100+4*i PRIO[i] RW.
//  Gateway per source, states IDLE -> PEND -> INSVC -> IDLE:
//   IDLE->PEND when src high (next cycle); PEND->INSVC on claim of its ID; INSVC->IDLE on complete of its ID.
//   Source held high in INSVC does not re-pend; after complete it re-pends the following cycle.
//   Pending is independent of enable (disabled sources still show in PEND).
//  Arbitration each cycle: candidates = pend & en & (prio > THRESH); winner = max prio, ties -> lowest index.
//   Result registered: intc_cpu_irq/intc_cpu_id update 1 cycle after any input/register change.
//  Claim read: returns current registered intc_cpu_id; if nonzero, that source moves to INSVC at end of
//   the access cycle and irq/id reflect next winner 1 cycle later. No winner -> reads 0, no state change.
//  Complete write: pwdata[ID_W-1:0]=ID; ignored if ID 0, ID > NUM_SRC, or source not INSVC.
//  Simultaneous: claim and source rise of other ID same cycle -> both take effect; complete and claim
//   in one cycle impossible (single APB port). PRIO/EN/THRESH write takes effect in next arbitration.
//  Reset mid-operation: all gateways return to IDLE immediately; irq drops asynchronously.
// STRUCTURE
//  apb_intc_pkg: register offset localparams, ID_W/PRIO_W defaults, gateway state enum.
//  Sub-module apb_intc_gateway (per-source 3-state FSM), instantiated NUM_SRC times via generate.
//  Top holds APB decode, EN/PRIO/THRESH regs, priority tree and output registers.
// TESTING
//  Reset: after presetn release all reads return 0, irq=0, id=0; src 0 high -> PEND_LO=0x1, irq stays 0.
//  Basic: EN_LO=0x1, PRIO[0]=1, src0 high -> irq=1,id=1; claim reads 1; irq=0 next cycle; complete 1,
//   src0 still high -> PEND_LO bit0 re-set next cycle, irq=1 again.
//  Priority: src5 PRIO=2, src12 PRIO=3, both enabled/high -> id=13; claim -> id=6; equal prio 2 -> id=6.
//  Threshold: THRESH=2, src5 PRIO=2 pending -> irq=0; THRESH=1 -> irq=1 one cycle after write.
//  Bad complete: complete ID 0, ID 41, ID of non-INSVC source -> no state change; claim with none -> 0.
//  Reset mid-op: src39 INSVC (EN_HI bit7), assert presetn low -> irq=0, PEND/EN/PRIO read 0 after release.

Source files
------------

// File: rtl/apb_intc_pkg.sv
// Shared constants and types for the APB interrupt controller.
package apb_intc_pkg;

    localparam int NUM_SRC = 40;
    localparam int PRIO_W  = 2;
    localparam int ID_W    = 6;

    // Register byte offsets within the 4 KiB peripheral window
    localparam logic [11:0] OFF_PEND_LO   = 12'h000;
    localparam logic [11:0] OFF_PEND_HI   = 12'h004;
    localparam logic [11:0] OFF_EN_LO     = 12'h008;
    localparam logic [11:0] OFF_EN_HI     = 12'h00C;
    localparam logic [11:0] OFF_THRESH    = 12'h010;
    localparam logic [11:0] OFF_CLAIM     = 12'h014;
    localparam logic [11:0] OFF_PRIO_BASE = 12'h100;

    // Per-source gateway life cycle
    typedef enum logic [1:0] {
        GW_IDLE  = 2'd0,
        GW_PEND  = 2'd1,
        GW_INSVC = 2'd2
    } gw_state_e;

endpackage

// File: rtl/apb_intc_if.sv
// APB slave-side bus bundle for the interrupt controller.
interface apb_intc_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;

    modport master (output psel, output penable, output pwrite,
                    output paddr, output pwdata, input prdata);
    modport slave  (input psel, input penable, input pwrite,
                    input paddr, input pwdata, output prdata);
endinterface

// File: rtl/apb_intc_gateway.sv
// Per-source gateway: latches a level request as pending, holds it
// in service between claim and complete so only one instance is live.
module apb_intc_gateway
    import apb_intc_pkg::*;
(
    input  logic pclk,
    input  logic presetn,
    input  logic src,
    input  logic claim,
    input  logic complete,
    output logic pend
);

    gw_state_e state_r;
    gw_state_e state_s;

    // State register
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_r <= GW_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state: a source held high while in service does not re-pend
    always_comb begin
        state_s = state_r;
        case (state_r)
            GW_IDLE: begin
                if (src) state_s = GW_PEND;
                else     state_s = GW_IDLE;
            end
            GW_PEND: begin
                if (claim) state_s = GW_INSVC;
                else       state_s = GW_PEND;
            end
            GW_INSVC: begin
                if (complete) state_s = GW_IDLE;
                else          state_s = GW_INSVC;
            end
            default: state_s = GW_IDLE;
        endcase
    end

    assign pend = (state_r == GW_PEND);

endmodule

// File: rtl/apb_intc.sv
// APB interrupt controller: register file, per-source gateways,
// priority arbitration and registered irq/ID to the CPU.
module apb_intc
    import apb_intc_pkg::*;
(
    input  logic               pclk,
    input  logic               presetn,
    apb_intc_if.slave          apb,
    input  logic [NUM_SRC-1:0] xx_intc_vld,
    output logic               intc_cpu_irq,
    output logic [ID_W-1:0]    intc_cpu_id
);

    localparam int HI_W = NUM_SRC - 32;

    logic               access_s;
    logic               rd_s;
    logic               wr_s;
    logic               prio_hit_s;
    logic [5:0]         prio_idx_s;
    logic [ID_W-1:0]    cmpl_id_s;
    logic [NUM_SRC-1:0] pend_s;
    logic [NUM_SRC-1:0] claim_s;
    logic [NUM_SRC-1:0] complete_s;
    logic [NUM_SRC-1:0] en_r;
    logic [PRIO_W-1:0]  prio_r [NUM_SRC];
    logic [PRIO_W-1:0]  thresh_r;
    logic [PRIO_W-1:0]  best_prio_s;
    logic [ID_W-1:0]    best_id_s;
    logic               irq_r;
    logic [ID_W-1:0]    id_r;
    logic [31:0]        rdata_s;

    assign access_s   = apb.psel & apb.penable;
    assign rd_s       = access_s & ~apb.pwrite;
    assign wr_s       = access_s & apb.pwrite;
    assign prio_idx_s = apb.paddr[7:2];
    assign prio_hit_s = (apb.paddr[11:8] == OFF_PRIO_BASE[11:8]) &&
                        (apb.paddr[1:0] == 2'b00) &&
                        (prio_idx_s < 6'(NUM_SRC));
    assign cmpl_id_s  = apb.pwdata[ID_W-1:0];

    // A claim reaches only the source named by the registered ID; ID 0 and
    // out-of-range complete IDs match no gateway and so have no effect.
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        assign claim_s[g]    = rd_s && (apb.paddr == OFF_CLAIM) && (id_r == ID_W'(g + 1));
        assign complete_s[g] = wr_s && (apb.paddr == OFF_CLAIM) && (cmpl_id_s == ID_W'(g + 1));

        apb_intc_gateway u_gw (
            .pclk     (pclk),
            .presetn  (presetn),
            .src      (xx_intc_vld[g]),
            .claim    (claim_s[g]),
            .complete (complete_s[g]),
            .pend     (pend_s[g])
        );
    end

    // Programmable enable, threshold and priority registers
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            en_r     <= '0;
            thresh_r <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                prio_r[i] <= '0;
            end
        end else if (wr_s) begin
            case (apb.paddr)
                OFF_EN_LO:  en_r[31:0]         <= apb.pwdata;
                OFF_EN_HI:  en_r[NUM_SRC-1:32] <= apb.pwdata[HI_W-1:0];
                OFF_THRESH: thresh_r           <= apb.pwdata[PRIO_W-1:0];
                default: begin
                    if (prio_hit_s) prio_r[prio_idx_s] <= apb.pwdata[PRIO_W-1:0];
                end
            endcase
        end
    end

    // Priority tree: strict '>' keeps the lowest index on ties, and seeding
    // with the threshold excludes anything at or below it. The source being
    // claimed this cycle is masked so the next winner appears one cycle on.
    always_comb begin
        best_prio_s = thresh_r;
        best_id_s   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pend_s[i] && en_r[i] && !claim_s[i] && (prio_r[i] > best_prio_s)) begin
                best_prio_s = prio_r[i];
                best_id_s   = ID_W'(i + 1);
            end else begin
                best_id_s   = best_id_s;
            end
        end
    end

    // Registered CPU-facing irq and ID
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            irq_r <= 1'b0;
            id_r  <= '0;
        end else begin
            irq_r <= (best_id_s != '0);
            id_r  <= best_id_s;
        end
    end

    assign intc_cpu_irq = irq_r;
    assign intc_cpu_id  = id_r;

    // Read data mux; zero outside a read access and for unmapped offsets
    always_comb begin
        rdata_s = 32'd0;
        if (rd_s) begin
            case (apb.paddr)
                OFF_PEND_LO: rdata_s = pend_s[31:0];
                OFF_PEND_HI: rdata_s = {{(32-HI_W){1'b0}}, pend_s[NUM_SRC-1:32]};
                OFF_EN_LO:   rdata_s = en_r[31:0];
                OFF_EN_HI:   rdata_s = {{(32-HI_W){1'b0}}, en_r[NUM_SRC-1:32]};
                OFF_THRESH:  rdata_s = {{(32-PRIO_W){1'b0}}, thresh_r};
                OFF_CLAIM:   rdata_s = {{(32-ID_W){1'b0}}, id_r};
                default: begin
                    if (prio_hit_s) rdata_s = {{(32-PRIO_W){1'b0}}, prio_r[prio_idx_s]};
                    else            rdata_s = 32'd0;
                end
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    assign apb.prdata = rdata_s;

endmodule

// File: tb/tb_apb_intc.sv
// Scoreboard bench for apb_intc: stimulus pushes expected read data and
// expected irq/id into queues; a negedge monitor pops and compares.
module tb_apb_intc;
    import apb_intc_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    logic               pclk;
    logic               presetn;
    logic [NUM_SRC-1:0] vld;
    logic               irq;
    logic [ID_W-1:0]    id;
    logic               probe;

    exp_t rd_q[$];
    exp_t irq_q[$];
    int   checks;
    int   failures;

    apb_intc_if bus ();

    apb_intc dut (
        .pclk         (pclk),
        .presetn      (presetn),
        .apb          (bus.slave),
        .xx_intc_vld  (vld),
        .intc_cpu_irq (irq),
        .intc_cpu_id  (id)
    );

    // Free-running clock
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Monitor: compare read data during each read access, and irq/id when probed
    always @(negedge pclk) begin
        exp_t e;
        if (bus.psel && bus.penable && !bus.pwrite) begin
            checks++;
            if (rd_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_read: addr=%h got=%h required=nothing queued", bus.paddr, bus.prdata);
            end else begin
                e = rd_q.pop_front();
                if (bus.prdata !== e.val) begin
                    failures++;
                    $display("FAIL %s: got=%h required=%h", e.name, bus.prdata, e.val);
                end
            end
        end
        if (probe) begin
            checks++;
            if (irq_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_probe: got irq=%b id=%0d required=nothing queued", irq, id);
            end else begin
                e = irq_q.pop_front();
                if ({25'd0, irq, id} !== e.val) begin
                    failures++;
                    $display("FAIL %s: got irq=%b id=%0d required irq=%b id=%0d",
                             e.name, irq, id, e.val[ID_W], e.val[ID_W-1:0]);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic apb_rd(input logic [11:0] addr, input logic [31:0] exp, input string name);
        exp_t e;
        e.name = name;
        e.val  = exp;
        bus.psel    = 1'b1;
        bus.pwrite  = 1'b0;
        bus.paddr   = addr;
        bus.penable = 1'b0;
        @(posedge pclk); #1;
        rd_q.push_back(e);
        bus.penable = 1'b1;
        @(posedge pclk); #1;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
    endtask

    task automatic apb_wr(input logic [11:0] addr, input logic [31:0] data);
        bus.psel    = 1'b1;
        bus.pwrite  = 1'b1;
        bus.paddr   = addr;
        bus.pwdata  = data;
        bus.penable = 1'b0;
        @(posedge pclk); #1;
        bus.penable = 1'b1;
        @(posedge pclk); #1;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
    endtask

    task automatic chk_irq(input logic e_irq, input logic [ID_W-1:0] e_id, input string name);
        exp_t e;
        e.name = name;
        e.val  = {25'd0, e_irq, e_id};
        irq_q.push_back(e);
        probe = 1'b1;
        @(negedge pclk); #1;
        probe = 1'b0;
        @(posedge pclk); #1;
    endtask

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus
    initial begin
        checks      = 0;
        failures    = 0;
        probe       = 1'b0;
        presetn     = 1'b0;
        vld         = '0;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        bus.paddr   = 12'h000;
        bus.pwdata  = 32'h0;
        tick(3);
        presetn = 1'b1;
        tick(1);

        // Reset state and unmapped offsets
        apb_rd(12'h000, 32'h0, "rst_pend_lo");
        apb_rd(12'h004, 32'h0, "rst_pend_hi");
        apb_rd(12'h008, 32'h0, "rst_en_lo");
        apb_rd(12'h00C, 32'h0, "rst_en_hi");
        apb_rd(12'h010, 32'h0, "rst_thresh");
        apb_rd(12'h100, 32'h0, "rst_prio0");
        apb_rd(12'h014, 32'h0, "rst_claim");
        chk_irq(1'b0, 6'd0, "rst_irq");
        apb_wr(12'h018, 32'hFFFF_FFFF);
        apb_rd(12'h018, 32'h0, "undef_018");
        apb_rd(12'h1A0, 32'h0, "undef_prio40");

        // Disabled source still shows pending but never interrupts
        vld = 40'h1;
        tick(2);
        apb_rd(12'h000, 32'h1, "pend_disabled");
        chk_irq(1'b0, 6'd0, "irq_disabled");

        // Basic claim / complete with source held high
        apb_wr(12'h008, 32'h1);
        apb_wr(12'h100, 32'h1);
        tick(1);
        chk_irq(1'b1, 6'd1, "basic_irq");
        apb_rd(12'h014, 32'd1, "basic_claim");
        chk_irq(1'b0, 6'd0, "basic_after_claim");
        apb_rd(12'h000, 32'h0, "basic_pend_insvc");
        apb_wr(12'h014, 32'd1);
        apb_rd(12'h000, 32'h1, "basic_repend");
        chk_irq(1'b1, 6'd1, "basic_irq_again");
        apb_rd(12'h014, 32'd1, "basic_claim2");
        vld = 40'h0;
        apb_wr(12'h014, 32'd1);

        // Priority ordering and ties
        apb_wr(12'h114, 32'd2);
        apb_wr(12'h130, 32'd3);
        apb_wr(12'h008, 32'h0000_1020);
        apb_rd(12'h008, 32'h0000_1020, "en_lo_readback");
        apb_rd(12'h130, 32'd3, "prio12_readback");
        vld = 40'h0000_1020;
        tick(2);
        chk_irq(1'b1, 6'd13, "prio_high_wins");
        apb_rd(12'h014, 32'd13, "prio_claim13");
        chk_irq(1'b1, 6'd6, "prio_next_winner");
        apb_wr(12'h130, 32'd2);
        apb_wr(12'h014, 32'd13);
        tick(3);
        chk_irq(1'b1, 6'd6, "prio_tie_low_index");
        apb_rd(12'h000, 32'h0000_1020, "prio_both_pend");
        apb_rd(12'h014, 32'd6, "prio_claim6");
        chk_irq(1'b1, 6'd13, "prio_after_claim6");

        // Threshold masking and one-cycle update
        apb_wr(12'h010, 32'd2);
        apb_wr(12'h014, 32'd6);
        tick(3);
        chk_irq(1'b0, 6'd0, "thresh_masks");
        apb_rd(12'h010, 32'd2, "thresh_readback");
        apb_wr(12'h010, 32'd1);
        chk_irq(1'b0, 6'd0, "thresh_same_cycle");
        chk_irq(1'b1, 6'd6, "thresh_next_cycle");

        // Bad completes leave state untouched
        apb_rd(12'h014, 32'd6, "bad_claim6");
        chk_irq(1'b1, 6'd13, "bad_winner13");
        apb_wr(12'h014, 32'd0);
        apb_wr(12'h014, 32'd41);
        apb_wr(12'h014, 32'd13);
        chk_irq(1'b1, 6'd13, "bad_cmpl_hold_a");
        chk_irq(1'b1, 6'd13, "bad_cmpl_hold_b");
        apb_rd(12'h000, 32'h0000_1000, "bad_pend_state");

        // Claim with nothing pending
        vld = '0;
        apb_rd(12'h014, 32'd13, "drain_claim13");
        apb_wr(12'h014, 32'd13);
        apb_wr(12'h014, 32'd6);
        tick(2);
        apb_rd(12'h014, 32'd0, "claim_none");
        chk_irq(1'b0, 6'd0, "irq_none");
        apb_rd(12'h000, 32'h0, "pend_none");

        // Top source, then reset while it is in service
        apb_wr(12'h19C, 32'd3);
        apb_wr(12'h00C, 32'h80);
        vld = 40'h80_0000_0000;
        tick(3);
        chk_irq(1'b1, 6'd40, "src39_irq");
        apb_rd(12'h004, 32'h80, "src39_pend_hi");
        apb_rd(12'h014, 32'd40, "src39_claim");
        apb_rd(12'h004, 32'h0, "src39_insvc");
        presetn = 1'b0;
        chk_irq(1'b0, 6'd0, "reset_irq_async");
        vld = '0;
        tick(2);
        presetn = 1'b1;
        tick(1);
        apb_rd(12'h004, 32'h0, "post_rst_pend_hi");
        apb_rd(12'h00C, 32'h0, "post_rst_en_hi");
        apb_rd(12'h008, 32'h0, "post_rst_en_lo");
        apb_rd(12'h19C, 32'h0, "post_rst_prio39");
        apb_rd(12'h010, 32'h0, "post_rst_thresh");
        chk_irq(1'b0, 6'd0, "post_rst_irq");

        tick(2);
        if (rd_q.size() != 0 || irq_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain: got rd=%0d irq=%0d required 0 0", rd_q.size(), irq_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
